// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC sequencer and its MAC pipeline.
package conv_pkg;

   localparam int DEF_INW            = 16;
   localparam int DEF_OUTW           = 64;
   localparam int DEF_PIPELINE_DEPTH = 5;
   localparam int DEF_NUM_TAPS       = 9;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_OUT    = 3'd4
   } state_t;

endpackage

// File: rtl/mac_pipe.sv
// Signed multiply-accumulate whose output trails the accumulator by PIPELINE_DEPTH cycles
// from the cycle input_valid is high.
module mac_pipe
   import conv_pkg::*;
#(
   parameter int INW            = DEF_INW,
   parameter int OUTW           = DEF_OUTW,
   parameter int PIPELINE_DEPTH = DEF_PIPELINE_DEPTH
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic signed [INW-1:0]  input0,
   input  logic signed [INW-1:0]  input1,
   input  logic signed [INW-1:0]  init_value,
   input  logic                   init_acc,
   input  logic                   input_valid,
   output logic signed [OUTW-1:0] out
);

   logic signed [2*INW-1:0] w_prod;
   logic signed [OUTW-1:0]  w_prod_ext;
   logic signed [OUTW-1:0]  w_init_ext;
   logic signed [OUTW-1:0]  r_acc;
   logic signed [OUTW-1:0]  r_dly [PIPELINE_DEPTH-1];

   assign w_prod     = input0 * input1;
   assign w_prod_ext = {{(OUTW-2*INW){w_prod[2*INW-1]}}, w_prod};
   assign w_init_ext = {{(OUTW-INW){init_value[INW-1]}}, init_value};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc <= '0;
      end else if (init_acc) begin
         r_acc <= w_init_ext;
      end else if (input_valid) begin
         r_acc <= r_acc + w_prod_ext;
      end
   end

   // The accumulator itself supplies one cycle of latency; the delay line supplies the rest.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PIPELINE_DEPTH-1; i++) r_dly[i] <= '0;
      end else begin
         r_dly[0] <= r_acc;
         for (int i = 1; i < PIPELINE_DEPTH-1; i++) r_dly[i] <= r_dly[i-1];
      end
   end

   assign out = r_dly[PIPELINE_DEPTH-2];

endmodule

// File: rtl/conv_mac_seq.sv
// Sequences one convolution output: seeds the MAC with a bias, streams NUM_TAPS operand
// pairs into it, waits out the MAC latency and presents the result on a valid/ready port.
module conv_mac_seq
   import conv_pkg::*;
#(
   parameter int INW            = DEF_INW,
   parameter int OUTW           = DEF_OUTW,
   parameter int PIPELINE_DEPTH = DEF_PIPELINE_DEPTH,
   parameter int NUM_TAPS       = DEF_NUM_TAPS
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic signed [INW-1:0]  bias,
   output logic                   busy,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic signed [INW-1:0]  s_data0,
   input  logic signed [INW-1:0]  s_data1,
   input  logic                   s_last,
   output logic signed [INW-1:0]  mac_input0,
   output logic signed [INW-1:0]  mac_input1,
   output logic signed [INW-1:0]  mac_init_value,
   output logic                   mac_init_acc,
   output logic                   mac_input_valid,
   input  logic signed [OUTW-1:0] mac_out,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic signed [OUTW-1:0] m_data,
   output logic                   err_len
);

   localparam int TAPW = $clog2(NUM_TAPS+1);
   localparam int DRW  = $clog2(PIPELINE_DEPTH+2);
   localparam logic [TAPW-1:0] TAP_LAST   = TAPW'(NUM_TAPS-1);
   localparam logic [DRW-1:0]  DRAIN_LAST = DRW'(PIPELINE_DEPTH);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [TAPW-1:0]        r_tap_cnt;
   logic [DRW-1:0]         r_drain_cnt;
   logic signed [INW-1:0]  r_bias;
   logic signed [INW-1:0]  r_in0;
   logic signed [INW-1:0]  r_in1;
   logic                   r_in_valid;
   logic                   r_err_len;
   logic signed [OUTW-1:0] r_m_data;
   logic                   w_xfer;
   logic                   w_tap_end;
   logic                   w_drain_done;

   assign w_xfer       = (r_state == ST_STREAM) && s_valid;
   assign w_tap_end    = (r_tap_cnt == TAP_LAST);
   assign w_drain_done = (r_drain_cnt == DRAIN_LAST);

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b1;
      s_ready      = 1'b0;
      m_valid      = 1'b0;
      mac_init_acc = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) w_state_next = ST_INIT;
         end
         ST_INIT: begin
            mac_init_acc = 1'b1;
            w_state_next = ST_STREAM;
         end
         ST_STREAM: begin
            s_ready = 1'b1;
            if (w_xfer && (s_last || w_tap_end)) w_state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_drain_done) w_state_next = ST_OUT;
         end
         ST_OUT: begin
            m_valid = 1'b1;
            if (m_ready) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tap_cnt   <= '0;
         r_drain_cnt <= '0;
         r_bias      <= '0;
         r_in0       <= '0;
         r_in1       <= '0;
         r_in_valid  <= 1'b0;
         r_err_len   <= 1'b0;
         r_m_data    <= '0;
      end else begin
         r_in_valid <= w_xfer;
         if (w_xfer) begin
            r_in0 <= s_data0;
            r_in1 <= s_data1;
         end
         if ((r_state == ST_IDLE) && start) r_bias <= bias;
         if (r_state == ST_INIT)  r_tap_cnt <= '0;
         else if (w_xfer)         r_tap_cnt <= r_tap_cnt + 1'b1;
         // Early s_last and a missing s_last on the final tap are both length errors.
         if (w_xfer && (s_last != w_tap_end)) r_err_len <= 1'b1;
         if (r_state == ST_DRAIN) begin
            if (w_drain_done) begin
               r_m_data    <= mac_out;
               r_drain_cnt <= '0;
            end else begin
               r_drain_cnt <= r_drain_cnt + 1'b1;
            end
         end else begin
            r_drain_cnt <= '0;
         end
      end
   end

   assign mac_input0      = r_in0;
   assign mac_input1      = r_in1;
   assign mac_init_value  = r_bias;
   assign mac_input_valid = r_in_valid;
   assign m_data          = r_m_data;
   assign err_len         = r_err_len;

endmodule
